// File: rtl/arcade_dial_emu.sv
// arcade_dial_emu: joystick up/down to spinner dial pulses or Gray quadrature, per-channel wrapping position.
// Define DIAL_ACCEL_EN to speed up the step rate on long runs (P/2 after 8 steps, P/4 after 24).
module arcade_dial_emu #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 16,
    parameter int QUAD   = 0,
    parameter int POS_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic [DIV_W-1:0]        period,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       invert,
    input  logic [NUM_CH-1:0]       up,
    input  logic [NUM_CH-1:0]       down,
    output logic [2*NUM_CH-1:0]     dial,
    output logic [POS_W*NUM_CH-1:0] pos,
    output logic [NUM_CH-1:0]       step
);
    typedef enum logic [1:0] {IDLE, FWD, REV, GAP} state_t;

    logic [DIV_W-1:0] p_base;
    assign p_base = (period == '0) ? DIV_W'(1) : period;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           st_q, st_d;
        logic [DIV_W-1:0] cnt_q, cnt_d, p_eff, h_eff;
        logic [POS_W-1:0] pos_q, pos_d;
        logic             step_q, step_d, fwd, rev, hit;
`ifdef DIAL_ACCEL_EN
        logic [4:0]       run_q, run_d;
        logic [DIV_W-1:0] p_sh;
        assign p_sh  = (run_q >= 5'd24) ? p_base >> 2 : (run_q >= 5'd8) ? p_base >> 1 : p_base;
        assign p_eff = (p_sh == '0) ? DIV_W'(1) : p_sh;
`else
        assign p_eff = p_base;
`endif
        assign h_eff = ((p_eff >> 1) == '0) ? DIV_W'(1) : p_eff >> 1;
        assign fwd   = (invert[g] ? down[g] : up[g]) & ~(up[g] & down[g]);
        assign rev   = (invert[g] ? up[g] : down[g]) & ~(up[g] & down[g]);
        // >= rather than == so a shortened period mid-run steps on the next tick
        assign hit   = cnt_q >= p_eff - DIV_W'(1);

        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            pos_d  = pos_q;
            step_d = 1'b0;
`ifdef DIAL_ACCEL_EN
            run_d  = run_q;
`endif
            if (!enable[g]) begin
                st_d  = IDLE;
                cnt_d = '0;
`ifdef DIAL_ACCEL_EN
                run_d = '0;
`endif
            end else if (ce) begin
                case (st_q)
                    IDLE: if (fwd || rev) begin
                        st_d   = fwd ? FWD : REV;
                        cnt_d  = '0;
                        step_d = 1'b1;
                        pos_d  = fwd ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    end
                    FWD, REV: if ((st_q == FWD) ? !fwd : !rev) begin
                        st_d  = GAP;
                        cnt_d = '0;
`ifdef DIAL_ACCEL_EN
                        run_d = '0;
`endif
                    end else if (hit) begin
                        cnt_d  = '0;
                        step_d = 1'b1;
                        pos_d  = (st_q == FWD) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
`ifdef DIAL_ACCEL_EN
                        if (run_q != 5'd24) run_d = run_q + 5'd1;
`endif
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                    default: if (cnt_q >= h_eff - DIV_W'(1)) begin
                        st_d  = IDLE;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q   <= IDLE;
                cnt_q  <= '0;
                pos_q  <= '0;
                step_q <= 1'b0;
`ifdef DIAL_ACCEL_EN
                run_q  <= '0;
`endif
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                pos_q  <= pos_d;
                step_q <= step_d;
`ifdef DIAL_ACCEL_EN
                run_q  <= run_d;
`endif
            end
        end

        // quadrature phase tracks the low position bits, so it only moves on steps
        assign dial[2*g +: 2] = (QUAD != 0) ? {pos_q[1], pos_q[1] ^ pos_q[0]} :
                                (st_q == FWD && cnt_q < h_eff) ? 2'b10 :
                                (st_q == REV && cnt_q < h_eff) ? 2'b01 : 2'b11;
        assign pos[POS_W*g +: POS_W] = pos_q;
        assign step[g] = step_q;
    end
endmodule

// File: tb/tb_arcade_dial_emu.sv
// tb_arcade_dial_emu: directed checks of pulse and quadrature dial instances sharing one stimulus.
module tb_arcade_dial_emu;
    logic        clk = 1'b0;
    logic        reset, ce;
    logic [15:0] period;
    logic [1:0]  enable, invert, up, down;
    logic [3:0]  dial, qdial;
    logic [15:0] pos, qpos;
    logic [1:0]  step, qstep;
    logic [7:0]  e;
    logic [1:0]  gq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    arcade_dial_emu #(.NUM_CH(2), .DIV_W(16), .QUAD(0), .POS_W(8)) u_dut (
        .clk(clk), .reset(reset), .ce(ce), .period(period), .enable(enable), .invert(invert),
        .up(up), .down(down), .dial(dial), .pos(pos), .step(step));

    arcade_dial_emu #(.NUM_CH(2), .DIV_W(16), .QUAD(1), .POS_W(8)) u_quad (
        .clk(clk), .reset(reset), .ce(ce), .period(period), .enable(enable), .invert(invert),
        .up(up), .down(down), .dial(qdial), .pos(qpos), .step(qstep));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; ce = 1'b1; period = 16'd4; enable = 2'b11; invert = 2'b10; up = 2'b00; down = 2'b00;
        #1 reset = 1'b1;
        #1;
        chk("rst_dial", 32'(dial), 32'hF);
        chk("rst_pos", 32'(pos), 32'h0);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_qdial", 32'(qdial), 32'h0);
        tick; tick;
        reset = 1'b0;
        up = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            tick;
            e = 8'((i + 3) / 4);
            chk("run_step", 32'(step), (i % 4 == 1) ? 32'h3 : 32'h0);
            chk("run_dial", 32'(dial), ((i - 1) % 4 < 2) ? 32'h6 : 32'hF);
            chk("run_pos", 32'(pos), {16'h0, 8'(-e), e});
        end
        up = 2'b00; down = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("gap_dial", 32'(dial), (i == 3) ? 32'hD : 32'hF);
            chk("gap_step", 32'(step), (i == 3) ? 32'h1 : 32'h0);
            chk("gap_pos", 32'(pos), (i == 3) ? 32'hFD02 : 32'hFD03);
        end
        tick; tick; tick; tick;
        chk("rev_step", 32'(step), 32'h1);
        chk("rev_pos", 32'(pos), 32'hFD01);
        chk("rev_dial", 32'(dial), 32'hD);
        down = 2'b00;
        tick;
        reset = 1'b1;
        #1;
        chk("qrst_dial", 32'(qdial), 32'h0);
        chk("qrst_pos", 32'(qpos), 32'h0);
        reset = 1'b0; period = 16'd0 + 16'd1; invert = 2'b00; down = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("quad_dial", 32'(qdial), {30'h0, gq[i]});
            chk("quad_pos", 32'(qpos), 32'(8'hFF - 8'(i)));
            chk("quad_step", 32'(qstep), 32'h1);
            if (i == 0) chk("p1_dial", 32'(dial), 32'hD);
        end
        up = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("both_step", 32'(qstep), 32'h0);
            chk("both_pos", 32'(qpos), 32'hFC);
            chk("both_dial", 32'(qdial), 32'h0);
        end
        down = 2'b00; period = 16'd4;
        tick;
        chk("en_step", 32'(step), 32'h1);
        chk("en_pos", 32'(pos[7:0]), 32'hFD);
        chk("en_dial", 32'(dial), 32'hE);
        ce = 1'b0; enable = 2'b10;
        tick;
        chk("dis_dial", 32'(dial), 32'hF);
        chk("dis_step", 32'(step), 32'h0);
        tick;
        chk("dis_hold", 32'(dial), 32'hF);
        chk("dis_pos", 32'(pos[7:0]), 32'hFD);
        enable = 2'b11; ce = 1'b1;
        tick;
        chk("reen_step", 32'(step), 32'h1);
        chk("reen_pos", 32'(pos[7:0]), 32'hFE);
        chk("reen_dial", 32'(dial), 32'hE);
        ce = 1'b0;
        tick; tick; tick;
        chk("ce0_step", 32'(step), 32'h0);
        chk("ce0_dial", 32'(dial), 32'hE);
        chk("ce0_pos", 32'(pos[7:0]), 32'hFE);
        ce = 1'b1; period = 16'd0;
        tick;
        chk("p0_step", 32'(step), 32'h1);
        chk("p0_pos", 32'(pos[7:0]), 32'hFF);
        tick;
        chk("wrap_step", 32'(step), 32'h1);
        chk("wrap_pos", 32'(pos[7:0]), 32'h00);
        chk("wrap_dial", 32'(dial), 32'hE);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
